// File: rtl/prbs_block_ctrl.sv
// Block sequencer for the 15-bit PRBS randomizer (1+x^14+x^15): seeds the LFSR once per
// FEC block, advances it once per accepted bit, and frames the block with first/last markers.
module prbs_block_ctrl #(
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             prbs_load,
  output logic             prbs_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state  | meaning
  // IDLE   | waiting for a start with a non-zero length
  // LOAD   | one cycle of seed load into the randomizer
  // RUN    | pass bits through, advance LFSR once per transfer
  // DONE   | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] count, count_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [LEN_W-1:0] len_m1;
  logic             err_q, err_nxt;
  logic             xfer;
  logic             at_last;

  assign len_m1  = len - {{(LEN_W-1){1'b0}}, 1'b1};
  assign at_last = (count == len_m1);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= S_IDLE;
      count <= '0;
      len   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      len   <= len_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    len_nxt   = len;
    err_nxt   = 1'b0;
    xfer      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    prbs_load = 1'b0;
    prbs_en   = 1'b0;
    done      = 1'b0;

    // abort outranks everything, including an illegal start that would otherwise flag err
    if (abort) begin
      state_nxt = S_IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_len != '0) begin
              len_nxt   = cfg_len;
              state_nxt = S_LOAD;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end

        S_LOAD: begin
          prbs_load = 1'b1;
          state_nxt = S_RUN;
          err_nxt   = start;
        end

        S_RUN: begin
          in_ready  = out_ready;
          out_valid = in_valid;
          xfer      = in_valid && out_ready;
          prbs_en   = xfer;
          out_first = in_valid && (count == '0);
          out_last  = in_valid && at_last;
          err_nxt   = start;
          if (xfer) begin
            if (at_last) begin
              count_nxt = '0;
              state_nxt = S_DONE;
            end else begin
              count_nxt = count + 1'b1;
            end
          end
        end

        S_DONE: begin
          done      = 1'b1;
          state_nxt = S_IDLE;
          err_nxt   = start;
        end

        default: begin
          state_nxt = S_IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign busy = (state == S_LOAD) || (state == S_RUN);
  assign err  = err_q;

endmodule

// File: tb/tb_prbs_block_ctrl.sv
// Bench for prbs_block_ctrl: directed block scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level model and a reference PRBS sequence.
module tb_prbs_block_ctrl;
  localparam int LEN_W = 11;
  localparam logic [14:0] SEED = 15'h4A80;

  logic             clk = 1'b0;
  logic             reset_N;
  logic             start, abort, in_valid, out_ready;
  logic [LEN_W-1:0] cfg_len;
  logic             in_ready, out_valid, out_first, out_last;
  logic             prbs_load, prbs_en, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;
  int en_seen;

  // reference sequence: E[0..14] is the seed, E[n] = E[n-14] ^ E[n-15]; bit k of a block is E[k+15]
  bit E [0:2047+15];

  // block-level model
  bit m_active, m_load_pend, m_done_pend, m_err_pend;
  int m_len, m_sent;

  // randomizer datapath stand-in, driven by the controller's load/en
  logic [14:0] lfsr;

  always #5 clk = ~clk;

  prbs_block_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_N   (reset_N),
    .start     (start),
    .abort     (abort),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .prbs_load (prbs_load),
    .prbs_en   (prbs_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(posedge clk or negedge reset_N) begin
    if (!reset_N)       lfsr <= SEED;
    else if (prbs_load) lfsr <= SEED;
    else if (prbs_en)   lfsr <= {lfsr[1] ^ lfsr[0], lfsr[14:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_load_pend = 1'b0;
    m_done_pend = 1'b0;
    m_err_pend  = 1'b0;
    m_len       = 0;
    m_sent      = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_first"}, out_first, 1'b0);
    chk({tag, "_out_last"},  out_last,  1'b0);
    chk({tag, "_prbs_load"}, prbs_load, 1'b0);
    chk({tag, "_prbs_en"},   prbs_en,   1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_done"},      done,      1'b0);
    chk({tag, "_err"},       err,       1'b0);
  endtask

  // one clock: drive inputs, check at negedge, advance model at posedge
  task automatic cycle(input logic s, input logic a, input logic [LEN_W-1:0] l,
                       input logic iv, input logic orr);
    bit running, e_valid, e_en, n_err;
    start = s; abort = a; cfg_len = l; in_valid = iv; out_ready = orr;
    @(negedge clk);
    running = m_active && !m_load_pend;
    e_valid = running && iv && !a;
    e_en    = e_valid && orr;
    chk("prbs_load", prbs_load, m_load_pend && !a);
    chk("in_ready",  in_ready,  running && orr && !a);
    chk("out_valid", out_valid, e_valid);
    chk("out_first", out_first, e_valid && (m_sent == 0));
    chk("out_last",  out_last,  e_valid && (m_sent == m_len - 1));
    chk("prbs_en",   prbs_en,   e_en);
    chk("busy",      busy,      m_active);
    chk("done",      done,      m_done_pend && !a);
    chk("err",       err,       m_err_pend);
    if (e_en) chk("prbs_bit", lfsr[1] ^ lfsr[0], E[m_sent + 15]);
    if (prbs_en) en_seen++;
    n_err = s && !a && (m_active || m_done_pend || (l == 0));
    @(posedge clk);
    m_err_pend = n_err;
    if (a) begin
      m_active = 1'b0; m_load_pend = 1'b0; m_done_pend = 1'b0; m_sent = 0;
    end else if (m_done_pend) begin
      m_done_pend = 1'b0;
    end else if (m_load_pend) begin
      m_load_pend = 1'b0;
    end else if (m_active) begin
      if (e_en) begin
        m_sent++;
        if (m_sent == m_len) begin
          m_active = 1'b0; m_sent = 0; m_done_pend = 1'b1;
        end
      end
    end else if (s && l != 0) begin
      m_active = 1'b1; m_load_pend = 1'b1; m_len = int'(l);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int j = 0; j < 15; j++) E[j] = SEED[j];
    for (int j = 15; j <= 2047 + 15; j++) E[j] = E[j-14] ^ E[j-15];

    reset_N = 1'b0;
    start = 1'b1; abort = 1'b0; cfg_len = 11'd5; in_valid = 1'b1; out_ready = 1'b1;
    model_reset();
    en_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_N = 1'b1;
    idle(2);

    // 96-bit block, no stalls
    en_seen = 0;
    cycle(1'b1, 1'b0, 11'd96, 1'b1, 1'b1);
    idle(100);
    chk("len96_en_count", en_seen, 96);

    // 8-bit block with out_ready toggling
    en_seen = 0;
    cycle(1'b1, 1'b0, 11'd8, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1, (i % 2) == 0);
    chk("len8_en_count", en_seen, 8);

    // zero length start, then start during RUN
    cycle(1'b1, 1'b0, 11'd0, 1'b1, 1'b1);
    idle(2);
    en_seen = 0;
    cycle(1'b1, 1'b0, 11'd10, 1'b1, 1'b1);
    idle(4);
    cycle(1'b1, 1'b0, 11'd3, 1'b1, 1'b1);
    idle(12);
    chk("start_in_run_en_count", en_seen, 10);

    // abort after six bits of a 20-bit block, then a fresh 4-bit block
    cycle(1'b1, 1'b0, 11'd20, 1'b1, 1'b1);
    idle(7);
    cycle(1'b0, 1'b1, '0, 1'b1, 1'b1);
    idle(2);
    cycle(1'b1, 1'b0, 11'd4, 1'b1, 1'b1);
    idle(8);

    // length 1, then back-to-back start right after done, then start+abort in IDLE
    cycle(1'b1, 1'b0, 11'd1, 1'b1, 1'b1);
    idle(3);
    cycle(1'b1, 1'b0, 11'd5, 1'b1, 1'b1);
    idle(9);
    cycle(1'b1, 1'b1, 11'd5, 1'b1, 1'b1);
    idle(3);

    // random traffic
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
            LEN_W'($urandom_range(0, 12)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle(2);

    // asynchronous reset in the middle of a block
    cycle(1'b1, 1'b0, 11'd50, 1'b1, 1'b1);
    idle(10);
    #3 reset_N = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1 reset_N = 1'b1;
    idle(5);
    cycle(1'b1, 1'b0, 11'd3, 1'b1, 1'b1);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
